// File: rtl/bp_me_rom_loader_pkg.sv
// Shared types and helpers for the boot ROM loader: FSM state encoding and
// the byte size of one ROM block.
package bp_me_rom_loader_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_fetch,
    e_send,
    e_drain,
    e_done
  } state_e;

  function automatic int block_bytes_lp(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Saturation-free up/down counter used to track outstanding write credits.
// The caller guarantees the count never leaves [0, max_val_p].
module bsg_counter_up_down #(
  parameter int max_val_p  = 2,
  parameter int init_val_p = 0,
  localparam int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      count_o <= width_lp'(init_val_p);
    else
      count_o <= count_o + width_lp'(up_i) - width_lp'(down_i);
  end

endmodule

// File: rtl/bp_me_rom_loader.sv
// Boot-time loader: walks a combinational boot ROM and writes each entry to
// memory as a block write, finishing once every write has been acknowledged.
module bp_me_rom_loader
  import bp_me_rom_loader_pkg::*;
#(
  parameter int data_width_p     = 512,
  parameter int rom_els_p        = 8,
  parameter int rom_addr_width_p = 3,
  parameter int mem_addr_width_p = 40,
  parameter logic [mem_addr_width_p-1:0] base_addr_p = '0,
  parameter int max_credits_p    = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic [rom_addr_width_p-1:0] rom_addr_o,
  input  logic [data_width_p-1:0]     rom_data_i,
  output logic                        mem_cmd_v_o,
  output logic [mem_addr_width_p-1:0] mem_cmd_addr_o,
  output logic [data_width_p-1:0]     mem_cmd_data_o,
  input  logic                        mem_cmd_ready_i,
  input  logic                        mem_resp_v_i,
  output logic                        mem_resp_yumi_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int credit_width_lp = $clog2(max_credits_p + 1);
  localparam logic [mem_addr_width_p-1:0] block_bytes_c =
    mem_addr_width_p'(block_bytes_lp(data_width_p));
  localparam logic [rom_addr_width_p-1:0] last_idx_c =
    rom_addr_width_p'(rom_els_p - 1);

  state_e state_r, state_n;
  logic [rom_addr_width_p-1:0] idx_r;
  logic [data_width_p-1:0]     data_r;
  logic [credit_width_lp-1:0]  credits;
  logic                        err_r;
  logic                        handshake;
  logic                        last_entry;
  logic                        credit_down;

  assign last_entry  = (idx_r == last_idx_c);
  assign handshake   = mem_cmd_v_o & mem_cmd_ready_i;
  // An ack with nothing outstanding is dropped so the credit count cannot underflow.
  assign credit_down = mem_resp_v_i & ((credits != '0) | handshake);

  bsg_counter_up_down #(
    .max_val_p (max_credits_p),
    .init_val_p(0)
  ) credit_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (handshake),
    .down_i (credit_down),
    .count_o(credits)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      state_r <= e_idle;
    else
      state_r <= state_n;
  end

  always_comb begin
    state_n     = state_r;
    mem_cmd_v_o = 1'b0;
    case (state_r)
      e_idle:  if (start_i) state_n = e_fetch;
      e_fetch: state_n = e_send;
      e_send: begin
        mem_cmd_v_o = (credits < credit_width_lp'(max_credits_p));
        if (mem_cmd_v_o && mem_cmd_ready_i)
          state_n = last_entry ? e_drain : e_fetch;
      end
      e_drain: if (credits == '0) state_n = e_done;
      e_done:  state_n = e_done;
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_r  <= '0;
      data_r <= '0;
      err_r  <= 1'b0;
    end else begin
      if (state_r == e_send && handshake && !last_entry)
        idx_r <= idx_r + 1'b1;
      if (state_r == e_fetch)
        data_r <= rom_data_i;
      if (mem_resp_v_i && credits == '0 && !handshake)
        err_r <= 1'b1;
    end
  end

  assign rom_addr_o      = idx_r;
  assign mem_cmd_data_o  = data_r;
  assign mem_cmd_addr_o  = base_addr_p + mem_addr_width_p'(idx_r) * block_bytes_c;
  assign mem_resp_yumi_o = mem_resp_v_i;
  assign busy_o          = (state_r == e_fetch) || (state_r == e_send) || (state_r == e_drain);
  assign done_o          = (state_r == e_done);
  assign err_o           = err_r;

endmodule

// File: tb/tb_bp_me_rom_loader.sv
// Scoreboard bench for the boot ROM loader: expected write commands are queued
// as stimulus is issued and a negedge monitor compares every accepted command.
module tb_bp_me_rom_loader;

  localparam int dw_lp = 512;
  localparam int aw_lp = 40;

  typedef struct {
    logic [aw_lp-1:0] addr;
    logic [dw_lp-1:0] data;
  } exp_cmd_t;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             start_i = 1'b0;
  logic [2:0]       rom_addr_o;
  logic [dw_lp-1:0] rom_data_i;
  logic             mem_cmd_v_o;
  logic [aw_lp-1:0] mem_cmd_addr_o;
  logic [dw_lp-1:0] mem_cmd_data_o;
  logic             mem_cmd_ready_i = 1'b1;
  logic             mem_resp_v_i;
  logic             mem_resp_yumi_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  logic auto_ack   = 1'b0;
  logic manual_ack = 1'b0;

  int checks    = 0;
  int passes    = 0;
  int cmd_count = 0;
  exp_cmd_t sb[$];
  exp_cmd_t mon_exp;

  bp_me_rom_loader dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .rom_addr_o     (rom_addr_o),
    .rom_data_i     (rom_data_i),
    .mem_cmd_v_o    (mem_cmd_v_o),
    .mem_cmd_addr_o (mem_cmd_addr_o),
    .mem_cmd_data_o (mem_cmd_data_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_v_i   (mem_resp_v_i),
    .mem_resp_yumi_o(mem_resp_yumi_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  // Boot ROM holds entry k = k; memory can ack in the same cycle a command is accepted.
  assign rom_data_i   = dw_lp'(rom_addr_o);
  assign mem_resp_v_i = manual_ack | (auto_ack & mem_cmd_v_o & mem_cmd_ready_i);

  // Monitor: every accepted command must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset_i && mem_cmd_v_o && mem_cmd_ready_i) begin
      cmd_count++;
      checks++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL unexpected_cmd: got addr=%0h data=%0h, required none",
                 mem_cmd_addr_o, mem_cmd_data_o[31:0]);
      end else begin
        mon_exp = sb.pop_front();
        if (mem_cmd_addr_o == mon_exp.addr && mem_cmd_data_o == mon_exp.data)
          passes++;
        else
          $display("[TB] FAIL cmd: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   mem_cmd_addr_o, mem_cmd_data_o[31:0], mon_exp.addr, mon_exp.data[31:0]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  task automatic pushExpected(input int first, input int last);
    exp_cmd_t e;
    for (int k = first; k <= last; k++) begin
      e.addr = aw_lp'(k * 64);
      e.data = dw_lp'(k);
      sb.push_back(e);
    end
  endtask

  // Pulses start for one cycle; returns #1 after the edge that samples it.
  task automatic applyStimulus();
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (!done_o && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("done_within_budget", 64'(done_o), 64'd1);
  endtask

  task automatic doReset();
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    reset_i = 1'b1;
    start_i = 1'b0;
    manual_ack = 1'b0;
    auto_ack = 1'b0;
    mem_cmd_ready_i = 1'b1;
    waitCycles(2);
    reset_i = 1'b0;
  endtask

  initial begin
    int cyc;
    int base_count;
    int budget;

    waitCycles(2);
    reset_i = 1'b0;
    checkOutput("reset_v", 64'(mem_cmd_v_o), 64'd0);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_done", 64'(done_o), 64'd0);
    checkOutput("reset_err", 64'(err_o), 64'd0);
    checkOutput("reset_rom_addr", 64'(rom_addr_o), 64'd0);

    $display("[TB] full load with same-cycle acks");
    auto_ack = 1'b1;
    pushExpected(0, 7);
    applyStimulus();
    checkOutput("busy_after_start", 64'(busy_o), 64'd1);
    waitDone(40, cyc);
    checkOutput("done_latency", 64'(cyc), 64'd17);
    checkOutput("busy_after_done", 64'(busy_o), 64'd0);
    checkOutput("err_after_load", 64'(err_o), 64'd0);

    $display("[TB] backpressure on entry 3");
    doReset();
    auto_ack = 1'b1;
    pushExpected(0, 7);
    applyStimulus();
    budget = 0;
    while (!(mem_cmd_v_o && rom_addr_o == 3'd3) && budget < 30) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("reached_entry3", 64'(rom_addr_o), 64'd3);
    mem_cmd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_v", 64'(mem_cmd_v_o), 64'd1);
      checkOutput("stall_addr", 64'(mem_cmd_addr_o), 64'hC0);
      checkOutput("stall_data", mem_cmd_data_o[63:0], 64'd3);
      @(posedge clk); #1;
    end
    mem_cmd_ready_i = 1'b1;
    waitDone(40, cyc);

    $display("[TB] credit limit with withheld acks");
    doReset();
    base_count = cmd_count;
    pushExpected(0, 1);
    applyStimulus();
    waitCycles(10);
    checkOutput("credit_limit_cmds", 64'(cmd_count - base_count), 64'd2);
    checkOutput("credit_limit_v", 64'(mem_cmd_v_o), 64'd0);
    checkOutput("credit_limit_busy", 64'(busy_o), 64'd1);
    pushExpected(2, 2);
    manual_ack = 1'b1;
    @(posedge clk); #1;
    manual_ack = 1'b0;
    waitCycles(6);
    checkOutput("one_ack_one_cmd", 64'(cmd_count - base_count), 64'd3);
    checkOutput("one_ack_v", 64'(mem_cmd_v_o), 64'd0);

    // Ack held across the cycle where entry 3 is accepted: the count must stay put,
    // leaving exactly one credit free for entry 4.
    $display("[TB] simultaneous handshake and ack");
    pushExpected(3, 4);
    manual_ack = 1'b1;
    waitCycles(2);
    manual_ack = 1'b0;
    waitCycles(8);
    checkOutput("simul_cmds", 64'(cmd_count - base_count), 64'd5);
    checkOutput("simul_v", 64'(mem_cmd_v_o), 64'd0);
    checkOutput("simul_err", 64'(err_o), 64'd0);

    $display("[TB] spurious ack and start in done");
    doReset();
    manual_ack = 1'b1;
    @(posedge clk); #1;
    manual_ack = 1'b0;
    checkOutput("spurious_err", 64'(err_o), 64'd1);
    checkOutput("spurious_v", 64'(mem_cmd_v_o), 64'd0);
    auto_ack = 1'b1;
    base_count = cmd_count;
    pushExpected(0, 7);
    applyStimulus();
    waitDone(40, cyc);
    checkOutput("spurious_then_latency", 64'(cyc), 64'd17);
    checkOutput("err_sticky", 64'(err_o), 64'd1);
    applyStimulus();
    waitCycles(10);
    checkOutput("start_in_done_cmds", 64'(cmd_count - base_count), 64'd8);
    checkOutput("start_in_done_done", 64'(done_o), 64'd1);
    checkOutput("start_in_done_busy", 64'(busy_o), 64'd0);

    $display("[TB] reset mid-load then reload");
    doReset();
    auto_ack = 1'b1;
    pushExpected(0, 3);
    applyStimulus();
    budget = 0;
    while (!(mem_cmd_v_o && rom_addr_o == 3'd4) && budget < 30) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("reached_entry4", 64'(rom_addr_o), 64'd4);
    mem_cmd_ready_i = 1'b0;
    checkOutput("scoreboard_before_reset", 64'(sb.size()), 64'd0);
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("async_reset_v", 64'(mem_cmd_v_o), 64'd0);
    checkOutput("async_reset_busy", 64'(busy_o), 64'd0);
    checkOutput("async_reset_rom_addr", 64'(rom_addr_o), 64'd0);
    checkOutput("async_reset_cmd_addr", 64'(mem_cmd_addr_o), 64'd0);
    checkOutput("async_reset_data", mem_cmd_data_o[63:0], 64'd0);
    checkOutput("async_reset_done", 64'(done_o), 64'd0);
    checkOutput("async_reset_err", 64'(err_o), 64'd0);
    waitCycles(2);
    reset_i = 1'b0;
    mem_cmd_ready_i = 1'b1;
    pushExpected(0, 7);
    applyStimulus();
    waitDone(40, cyc);
    checkOutput("reload_latency", 64'(cyc), 64'd17);
    checkOutput("final_scoreboard", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
